uart_tx_param: RTL

//  Parametrised UART transmitter. Successor to the fixed 8-bit single-word TX.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_param_if.sv | 34 +++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter: FSM states, parity
// encodings and the FIFO entry that carries a word plus its frame settings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // FIFO entries are sized for the widest legal word; narrower words are zero-extended.
    localparam int MAX_DATA_WIDTH = 9;

    typedef struct packed {
        logic                      stop_two;
        logic                      parity_type;
        logic                      parity_enable;
        logic [MAX_DATA_WIDTH-1:0] data;
    } tx_word_t;

    // Zero-extension does not disturb the XOR reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      ptype);
        return (ptype == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side write port of the UART transmitter: word, frame settings and handshake.
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8
) ();

    // Handshake: a word (with its parity/stop settings) is accepted on every rising
    // clock edge where Data_Valid and data_ready are both high. data_ready is purely
    // "FIFO not full"; a Data_Valid seen while data_ready is low is dropped, not held.
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  data_ready;
    logic                  parity_enable;
    logic                  parity_type;
    logic                  stop_two;

    modport master (
        output P_DATA,
        output Data_Valid,
        output parity_enable,
        output parity_type,
        output stop_two,
        input  data_ready
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  parity_enable,
        input  parity_type,
        input  stop_two,
        output data_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the transmitter; pointers carry a wrap bit so
// full and empty are told apart without a separate counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  tx_word_t               wr_data,
    input  logic                   rd_en,
    output tx_word_t               rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    tx_word_t    mem [DEPTH];
    logic        do_wr;
    logic        do_rd;

    // A write is refused whenever full, even if a pop happens in the same cycle.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q[AW-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: queued words are framed as start, data (LSB first),
// optional parity and one or two stop bits, with back-to-back frames when queued.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    uart_tx_param_if.slave              wr,
    output logic                        TX_OUT,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output tx_state_e                   state_dbg
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    tx_word_t wr_word;
    tx_word_t rd_word;
    logic     fifo_full;
    logic     fifo_empty;
    logic     pop;

    // Frame settings travel with the word so later input changes cannot touch it.
    always_comb begin
        wr_word               = '0;
        wr_word.stop_two      = wr.stop_two;
        wr_word.parity_type   = wr.parity_type;
        wr_word.parity_enable = wr.parity_enable;
        wr_word.data          = MAX_DATA_WIDTH'(wr.P_DATA);
    end

    assign wr.data_ready = ~fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr.Data_Valid),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    tx_state_e             state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic                  pe_q,     pe_d;
    logic                  par_q,    par_d;
    logic                  st_q,     st_d;
    logic                  stop2_q,  stop2_d;
    logic                  tx_q,     tx_d;
    logic                  busy_q,   busy_d;
    logic                  bit_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= CNT_MAX;
            idx_q   <= '0;
            shift_q <= '0;
            pe_q    <= 1'b0;
            par_q   <= 1'b0;
            st_q    <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pe_q    <= pe_d;
            par_q   <= par_d;
            st_q    <= st_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pe_d     = pe_q;
        par_d    = par_q;
        st_d     = st_q;
        stop2_d  = stop2_q;
        pop      = 1'b0;
        bit_done = (cnt_q == '0);
        cnt_d    = bit_done ? CNT_MAX : (cnt_q - CNT_ONE);

        case (state_q)
            IDLE: begin
                cnt_d = CNT_MAX;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        state_d = pe_q ? PARITY : STOP;
                        stop2_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    stop2_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (st_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = rd_word.data[DATA_WIDTH-1:0];
            pe_d    = rd_word.parity_enable;
            st_d    = rd_word.stop_two;
            par_d   = calc_parity(rd_word.data, rd_word.parity_type);
        end

        // The line and busy lag the state by one edge, so both change together.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE);
    end

    assign TX_OUT    = tx_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
